// File: rtl/tone_player_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tone_player_pkg : state enum, octave codes and half-period table shared   |
// |                   by the tone player and the existing buzzer logic        |
// | Revision        : 1.0                                                     |
// +--------------------------------------------------------------------------+
package tone_player_pkg;

  localparam int HALF_W = 21;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [1:0] OCT_LOW  = 2'b01;
  localparam logic [1:0] OCT_HIGH = 2'b10;

  // Base half-periods in clk cycles for do..si
  localparam logic [HALF_W-1:0] HALF_TABLE [7] = '{
    21'd381680, 21'd340136, 21'd303030, 21'd285714,
    21'd255102, 21'd227273, 21'd202429
  };

  function automatic logic [HALF_W-1:0] calc_half(input logic [2:0] idx,
                                                   input logic [1:0] oct,
                                                   input int         shift);
    logic [HALF_W-1:0] h;
    h = '0;
    if (idx != 3'd0) h = HALF_TABLE[idx - 3'd1] >> shift;
    case (oct)
      OCT_LOW:  h = h << 1;
      OCT_HIGH: h = h >> 1;
      default:  h = h;
    endcase
    if (h == '0) h = HALF_W'(1);
    return h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tone_player_osc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tone_player_osc : half-period counter and speaker toggle                  |
// | Revision        : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tone_player_osc
  import tone_player_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [HALF_W-1:0] half,
  output logic              speaker
);

  logic [HALF_W-1:0] cnt;

  // Period is exactly 2*half: toggle on the last count, then restart at 0
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt     <= '0;
      speaker <= 1'b0;
    end else if (en) begin
      if (cnt == half - HALF_W'(1)) begin
        cnt     <= '0;
        speaker <= ~speaker;
      end else begin
        cnt <= cnt + HALF_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tone_player.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tone_player : plays one note request as a square wave for dur ticks;      |
// |               optional trailing silence enabled by TONE_PLAYER_GAP_EN     |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
module tone_player
  import tone_player_pkg::*;
#(
  parameter int NOTE_W      = 4,
  parameter int DUR_W       = 8,
  parameter int TICK_DIV    = 100000,
  parameter int PITCH_SHIFT = 0,
  parameter int GAP_TICKS   = 10
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NOTE_W-1:0] in_note,
  input  logic [1:0]        in_octave,
  input  logic [DUR_W-1:0]  in_dur,
  input  logic              abort,
  output logic              speaker,
  output logic              busy,
  output logic              done
);

  localparam int              PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  state_t             state;
  logic [NOTE_W-1:0]  note_q;
  logic [1:0]         oct_q;
  logic [DUR_W-1:0]   dur_q;
  logic [PRE_W-1:0]   presc;
  logic [DUR_W-1:0]   tick_cnt;

  logic               tick;
  logic               play_end;
  logic               is_tone;
  logic               osc_en;
  logic               osc_clr;
  logic [HALF_W-1:0]  half;

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

  assign tick     = (presc == PRE_MAX);
  assign play_end = (dur_q == '0) || (tick && (tick_cnt == dur_q - DUR_W'(1)));
  assign is_tone  = (note_q != '0) && ((note_q >> 3) == '0);
  assign half     = calc_half(note_q[2:0], oct_q, PITCH_SHIFT);

  // Clearing on the exit edge itself makes the speaker low in the first cycle after PLAY
  assign osc_en   = (state == ST_PLAY) && is_tone;
  assign osc_clr  = (state != ST_PLAY) || abort || play_end;

`ifdef TONE_PLAYER_GAP_EN
  localparam int GAP_W = (GAP_TICKS <= 1) ? 1 : $clog2(GAP_TICKS);
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_end;
  assign gap_end = (GAP_TICKS == 0) || (tick && (gap_cnt == GAP_W'(GAP_TICKS - 1)));
`else
  logic unused_gap_cfg;
  assign unused_gap_cfg = ^GAP_TICKS;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      note_q   <= '0;
      oct_q    <= '0;
      dur_q    <= '0;
      presc    <= '0;
      tick_cnt <= '0;
      done     <= 1'b0;
`ifdef TONE_PLAYER_GAP_EN
      gap_cnt  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            note_q   <= in_note;
            oct_q    <= in_octave;
            dur_q    <= in_dur;
            presc    <= '0;
            tick_cnt <= '0;
            state    <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (abort) begin
            presc    <= '0;
            tick_cnt <= '0;
            state    <= ST_IDLE;
          end else if (play_end) begin
            presc    <= '0;
            tick_cnt <= '0;
`ifdef TONE_PLAYER_GAP_EN
            gap_cnt  <= '0;
            state    <= ST_GAP;
`else
            done     <= 1'b1;
            state    <= ST_IDLE;
`endif
          end else begin
            presc <= tick ? '0 : presc + PRE_W'(1);
            if (tick) tick_cnt <= tick_cnt + DUR_W'(1);
          end
        end
`ifdef TONE_PLAYER_GAP_EN
        ST_GAP: begin
          if (abort) begin
            presc   <= '0;
            gap_cnt <= '0;
            state   <= ST_IDLE;
          end else if (gap_end) begin
            presc   <= '0;
            gap_cnt <= '0;
            done    <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            presc <= tick ? '0 : presc + PRE_W'(1);
            if (tick) gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  tone_player_osc u_osc (
    .clk     (clk),
    .rst     (rst),
    .en      (osc_en),
    .clr     (osc_clr),
    .half    (half),
    .speaker (speaker)
  );

endmodule
`default_nettype wire

// File: tb/tb_tone_player.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tone_player : randomized note requests checked by a waveform model     |
// | Revision       : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_tone_player;

  localparam int TICK = 10;
`ifdef TONE_PLAYER_GAP_EN
  localparam int GAP_CYC = 3 * TICK;
`else
  localparam int GAP_CYC = 0;
`endif

  typedef struct {
    int note;
    int oct;
    int dur;
    int cut;   // cycle index of abort/reset within the note, -1 for none
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_note = '0;
  logic [1:0] in_octave = '0;
  logic [7:0] in_dur = '0;
  logic       abort = 1'b0;
  logic       speaker;
  logic       busy;
  logic       done;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  bit   in_trans = 1'b0;

  always #5 clk = ~clk;

  tone_player #(
    .NOTE_W(4), .DUR_W(8), .TICK_DIV(TICK), .PITCH_SHIFT(12), .GAP_TICKS(3)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_note(in_note), .in_octave(in_octave), .in_dur(in_dur),
    .abort(abort), .speaker(speaker), .busy(busy), .done(done)
  );

  task automatic chk(input string name, input int act, input int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  function automatic int half_of(input int note, input int oct);
    int base[7] = '{381680, 340136, 303030, 285714, 255102, 227273, 202429};
    int h;
    h = base[note-1] / 4096;
    if (oct == 1) h = h * 2;
    else if (oct == 2) h = h / 2;
    if (h == 0) h = 1;
    return h;
  endfunction

  function automatic int play_cycles(input int dur);
    return (dur == 0) ? 1 : dur * TICK;
  endfunction

  task automatic finish_tb();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  // Monitor: collect the speaker trace over each busy window, compare with the model
  initial begin : monitor
    bit   trace[$];
    int   dcount;
    exp_t e;
    int   explen, plen, h, bad;
    bit   tone, want;
    forever begin
      @(negedge clk);
      if (busy) begin
        if (!in_trans) begin
          in_trans = 1'b1;
          trace.delete();
          dcount = 0;
        end
        trace.push_back(speaker);
        if (done) dcount++;
      end else if (in_trans) begin
        in_trans = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_note", 1, 0);
        end else begin
          e      = exp_q.pop_front();
          plen   = play_cycles(e.dur);
          explen = (e.cut >= 0) ? e.cut + 1 : plen + GAP_CYC;
          tone   = (e.note >= 1 && e.note <= 7);
          h      = tone ? half_of(e.note, e.oct) : 1;
          bad    = -1;
          foreach (trace[k]) begin
            want = tone && (k < plen) && (((k / h) % 2) == 1);
            if (trace[k] != want && bad < 0) bad = k;
          end
          chk("busy_len", trace.size(), explen);
          chk("speaker_wave_first_bad_cycle", bad, -1);
          chk("done_at_end", int'(done), (e.cut < 0) ? 1 : 0);
          chk("done_while_busy", dcount, 0);
          chk("speaker_after_note", int'(speaker), 0);
        end
      end else if (done) begin
        chk("spurious_done", 1, 0);
      end
    end
  end

  task automatic send(input int note, input int oct, input int dur,
                      input int cut, input bit use_rst, input bit ab_idle);
    exp_t e;
    bit   rdy;
    bit   ok;
    e  = '{note, oct, dur, cut};
    exp_q.push_back(e);
    ok = 1'b0;
    in_note   = 4'(note);
    in_octave = 2'(oct);
    in_dur    = 8'(dur);
    in_valid  = 1'b1;
    // in_valid is held while busy; acceptance must wait for in_ready
    for (int n = 0; n < 4000; n++) begin
      rdy   = in_ready;
      abort = ab_idle && in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    abort    = 1'b0;
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      finish_tb();
    end
    if (cut >= 0) begin
      repeat (cut) @(posedge clk);
      #1;
      if (use_rst) rst = 1'b1;
      else abort = 1'b1;
      @(posedge clk);
      #1;
      if (use_rst) begin
        chk("rst_speaker", int'(speaker), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        rst = 1'b0;
      end else begin
        chk("abort_to_idle", int'(busy), 0);
        abort = 1'b0;
      end
    end
  endtask

  initial begin : stim
    int note, oct, dur, full, cut;
    bit ok;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_speaker", int'(speaker), 0);
    chk("reset_done", int'(done), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    send(1, 0, 100, -1, 0, 0);
    send(1, 1, 20, -1, 0, 0);
    send(1, 2, 20, -1, 0, 0);
    send(0, 0, 5, -1, 0, 0);
    send(9, 3, 5, -1, 0, 0);
    send(3, 0, 0, -1, 0, 0);
    send(5, 1, 0, -1, 0, 0);
    send(2, 0, 0, -1, 0, 1);
    send(1, 0, 4, -1, 0, 0);
    send(1, 0, 100, 300, 0, 0);
    send(2, 0, 50, 123, 1, 0);
    send(4, 2, 10, -1, 0, 1);
    send(6, 0, 3, 3 * TICK + GAP_CYC - 1, 0, 0);
    send(7, 3, 2, 0, 1, 0);

    for (int i = 0; i < 20; i++) begin
      note = $urandom_range(0, 15);
      oct  = $urandom_range(0, 3);
      dur  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
      full = play_cycles(dur) + GAP_CYC;
      cut  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, full - 1) : -1;
      send(note, oct, dur, cut, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    ok = 1'b0;
    for (int n = 0; n < 6000; n++) begin
      @(posedge clk);
      if (exp_q.size() == 0 && !in_trans) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_timeout", int'(ok), 1);
    repeat (3) @(posedge clk);
    finish_tb();
  end

endmodule
`default_nettype wire

// File: doc/tone_player.md
TONE_PLAYER -- requirements
Module: tone_player

Interface
REQ-001 Parameter NOTE_W, default 4, width of note code.
REQ-002 Parameter DUR_W, default 8, width of duration field, in ticks.
REQ-003 Parameter TICK_DIV, default 100000, clk cycles per duration tick (1 ms at 100 MHz); legal range is 1 or more.
REQ-004 Parameter PITCH_SHIFT, default 0, right shift applied to every half-period table entry (simulation speed-up).
REQ-005 Parameter GAP_TICKS, default 10, silent ticks after each note (used only with gap feature).
REQ-006 clk  input  1  sole clock, all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 in_valid  input  1  note request valid.
REQ-009 in_ready  output  1  block can accept a request.
REQ-010 in_note  input  NOTE_W  note code: 0 is rest, 1-7 are do..si, 8 and above are rest.
REQ-011 in_octave  input  2  octave: 01 is lower, 10 is higher, any other value is standard.
REQ-012 in_dur  input  DUR_W  note length in ticks.
REQ-013 abort  input  1  cancel current note.
REQ-014 speaker  output  1  square-wave output.
REQ-015 busy  output  1  high whenever the state is not IDLE.
REQ-016 done  output  1  one-cycle pulse when a note (including its gap) completes normally.

Function
REQ-017 States: IDLE, PLAY, GAP.
REQ-018 in_ready SHALL equal (state==IDLE).
REQ-019 A request is accepted when in_valid && in_ready are both high. On acceptance, note, octave and dur are registered and the state goes to PLAY on the next cycle.
REQ-020 Base half-periods in cycles: do 381680, re 340136, mi 303030, fa 285714, so 255102, la 227273, si 202429. Each entry is shifted right by PITCH_SHIFT.
REQ-021 Octave adjustment:
- lower: half-period shifted left by 1.
- higher: half-period shifted right by 1.
- standard: unchanged.
- Internal half-period width is 21 bits.
- A computed half-period of 0 is clamped to 1.
REQ-022 Tone counter: counts 0..H-1, toggles speaker when it reaches H-1 and restarts at 0, so the output period is exactly 2*H cycles.
REQ-023 On entry to PLAY, speaker is 0 and the tone counter is 0. The first toggle occurs H cycles after entry.
REQ-024 Rest note: speaker is held 0 for the full duration. Timing is identical to a tone note.
REQ-025 Tick prescaler runs only in PLAY/GAP. It is cleared on every state entry and pulses every TICK_DIV cycles.
REQ-026 PLAY lasts exactly in_dur*TICK_DIV cycles. in_dur==0 means PLAY lasts 1 cycle with no toggle.
REQ-027 Leaving PLAY forces speaker to 0 on the next cycle.
REQ-028 abort, when high in PLAY or GAP:
- next state is IDLE and speaker goes to 0;
- no done pulse is produced;
- abort has priority over completion in the same cycle.
REQ-029 abort in IDLE is ignored. abort and in_valid high together in IDLE: the request is accepted.
REQ-030 done pulses in the cycle the state returns to IDLE after normal completion. A new request may be accepted starting the following cycle.

Reset
REQ-031 While rst is high, the following apply on the next edge:
- state becomes IDLE;
- speaker, done and busy become 0;
- in_ready becomes 1;
- all counters and registered fields become 0.
REQ-032 Reset mid-note aborts the note with no done pulse and overrides abort and in_valid.

Configuration
REQ-033 Macro TONE_PLAYER_GAP_EN.
- Defined: PLAY is followed by GAP, which lasts GAP_TICKS*TICK_DIV cycles with speaker 0; done is issued at the end of GAP.
- Undefined: the GAP state and its counter are absent, PLAY returns directly to IDLE with done, and GAP_TICKS is ignored.

Structure
REQ-034 Package tone_player_pkg SHALL hold the following, shared with the existing buzzer logic:
- the state enum;
- the octave code constants;
- the 7-entry half-period table;
- the half-period width constant.
REQ-035 One sub-module, tone_player_osc, SHALL contain the half-period tone counter and speaker toggle, with enable and clear inputs.

Verification
REQ-036 Common bench settings: TICK_DIV=10, PITCH_SHIFT=12, so do half-period = 93.
REQ-037 Scenario 1: note=1, octave=00, dur=100 -> busy for 1000 cycles; speaker period 186 cycles; done pulses once; speaker ends at 0.
REQ-038 Scenario 2: note=1, octave 01 then 10 -> periods 372 and 92 cycles (H=46).
REQ-039 Scenario 3: note=0 and note=9, dur=5 -> speaker stays 0 for 50 cycles, then done.
REQ-040 Scenario 4: dur=0 -> PLAY lasts 1 cycle, no toggle, done; back-to-back requests -> each accepted only when in_ready is high.
REQ-041 Scenario 5: abort at cycle 300 of a dur=100 note -> IDLE next cycle, speaker 0, no done; rst asserted mid-note -> all outputs reach their reset values.
REQ-042 Scenario 6 (TONE_PLAYER_GAP_EN, GAP_TICKS=3): dur=4 -> 40 cycles tone, then 30 cycles silence, then done; without the macro, done follows the 40 tone cycles directly.
